// File: rtl/issue_scoreboard_pkg.sv
// Shared encodings for the issue scoreboard (package issue_pkg).
// The field encodings match the ones decode_unit produces.
package issue_pkg;

    localparam int NREG = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_BR = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    localparam logic [1:0] WB_NONE    = 2'd0;
    localparam logic [1:0] WB_RD      = 2'd1;
    localparam logic [1:0] WB_ADDR    = 2'd2;

    localparam logic [1:0] JMP_SEQ    = 2'd0;
    localparam logic [1:0] JMP_JUMP   = 2'd1;
    localparam logic [1:0] JMP_BRANCH = 2'd2;

    localparam logic [1:0] MEM_NONE   = 2'd0;
    localparam logic [1:0] MEM_LOAD   = 2'd1;
    localparam logic [1:0] MEM_STORE  = 2'd2;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register vector: one set and one clear per cycle, set wins on a collision.
// Register x0 is never marked busy.
import issue_pkg::*;

module reg_scoreboard (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [4:0]      set_rd,
    input  logic            clr_en,
    input  logic [4:0]      clr_rd,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_rd] = 1'b1;
        if (clr_en) clr_mask[clr_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= ((busy & ~clr_mask) | set_mask) & {{(NREG-1){1'b1}}, 1'b0};
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue register with RAW/WAW hazard, memory-limit and branch stalls; halts on decode faults.
// Optional macro ISSUE_SCOREBOARD_WB_BYPASS_EN lets a retiring writeback unblock issue in the same cycle.
//
// state      | meaning
// ST_RUN     | normal issue
// ST_WAIT_BR | jump/branch issued, waiting for br_resolve
// ST_HALT    | decode fault accepted, stuck until rst
import issue_pkg::*;

module issue_scoreboard #(
    parameter int MEM_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [4:0]  dec_rd,
    input  logic [31:0] dec_active_reg,
    input  logic [1:0]  dec_wb_op,
    input  logic [1:0]  dec_jmp_op,
    input  logic [1:0]  dec_mem_op,
    input  logic        dec_fault,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [4:0]  iss_rd,
    output logic [1:0]  iss_wb_op,
    output logic [1:0]  iss_jmp_op,
    output logic [1:0]  iss_mem_op,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        mem_done,
    input  logic        br_resolve,
    output logic [31:0] busy_regs,
    output logic        fault_o,
    output logic        halted
);

    localparam logic [2:0] MEM_LIMIT = 3'(MEM_MAX);

    state_t          state;
    logic [2:0]      mem_cnt;
    logic [NREG-1:0] busy_eff;
    logic            hazard;
    logic            slot_free;
    logic            mem_ok;
    logic            in_run;
    logic            accept;
    logic            take_fault;
    logic            mem_inc;
    logic            mem_dec;

`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    always_comb begin
        busy_eff = busy_regs;
        if (wb_valid) busy_eff[wb_rd] = 1'b0;
    end
`else
    assign busy_eff = busy_regs;
`endif

    assign hazard     = (|(dec_active_reg & busy_eff)) ||
                        ((dec_wb_op != WB_NONE) && (dec_rd != 5'd0) && busy_eff[dec_rd]);
    assign slot_free  = !iss_valid || iss_ready;
    assign mem_ok     = (dec_mem_op == MEM_NONE) || (mem_cnt < MEM_LIMIT);
    assign in_run     = (state == ST_RUN);
    assign take_fault = dec_valid && dec_fault && in_run;
    assign accept     = dec_valid && !dec_fault && in_run && !hazard && slot_free && mem_ok;
    assign dec_ready  = take_fault || accept;

    assign mem_inc = accept && (dec_mem_op != MEM_NONE);
    assign mem_dec = mem_done && (mem_cnt != 3'd0);

    reg_scoreboard u_busy (
        .clk    (clk),
        .rst    (rst),
        .set_en (accept && (dec_wb_op != WB_NONE)),
        .set_rd (dec_rd),
        .clr_en (wb_valid),
        .clr_rd (wb_rd),
        .busy   (busy_regs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            fault_o <= 1'b0;
            halted  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take_fault) begin
                        state   <= ST_HALT;
                        fault_o <= 1'b1;
                        halted  <= 1'b1;
                    end else if (accept && (dec_jmp_op != JMP_SEQ)) begin
                        state <= ST_WAIT_BR;
                    end
                end
                ST_WAIT_BR: if (br_resolve) state <= ST_RUN;
                ST_HALT:    state <= ST_HALT;
                default:    state <= ST_RUN;
            endcase
        end
    end

    // Simultaneous increment and decrement cancel; the limit check keeps the count <= MEM_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_cnt <= 3'd0;
        else if (mem_inc && !mem_dec)
            mem_cnt <= mem_cnt + 3'd1;
        else if (!mem_inc && mem_dec)
            mem_cnt <= mem_cnt - 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid  <= 1'b0;
            iss_rd     <= 5'd0;
            iss_wb_op  <= WB_NONE;
            iss_jmp_op <= JMP_SEQ;
            iss_mem_op <= MEM_NONE;
        end else if (accept) begin
            iss_valid  <= 1'b1;
            iss_rd     <= dec_rd;
            iss_wb_op  <= dec_wb_op;
            iss_jmp_op <= dec_jmp_op;
            iss_mem_op <= dec_mem_op;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the issue rules.
module tb_issue_scoreboard;

    localparam int MEM_MAX = 2;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rd;
    logic [31:0] dec_active_reg;
    logic [1:0]  dec_wb_op;
    logic [1:0]  dec_jmp_op;
    logic [1:0]  dec_mem_op;
    logic        dec_fault;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic [1:0]  iss_wb_op;
    logic [1:0]  iss_jmp_op;
    logic [1:0]  iss_mem_op;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        mem_done;
    logic        br_resolve;
    logic [31:0] busy_regs;
    logic        fault_o;
    logic        halted;

    always #5 clk = ~clk;

    issue_scoreboard #(.MEM_MAX(MEM_MAX)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_rd         (dec_rd),
        .dec_active_reg (dec_active_reg),
        .dec_wb_op      (dec_wb_op),
        .dec_jmp_op     (dec_jmp_op),
        .dec_mem_op     (dec_mem_op),
        .dec_fault      (dec_fault),
        .iss_valid      (iss_valid),
        .iss_ready      (iss_ready),
        .iss_rd         (iss_rd),
        .iss_wb_op      (iss_wb_op),
        .iss_jmp_op     (iss_jmp_op),
        .iss_mem_op     (iss_mem_op),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .mem_done       (mem_done),
        .br_resolve     (br_resolve),
        .busy_regs      (busy_regs),
        .fault_o        (fault_o),
        .halted         (halted)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: set of busy registers, count of memory ops in flight,
    // "waiting for a branch" / "halted" flags and a copy of the issued instruction.
    logic [31:0] m_busy;
    int          m_cnt;
    bit          m_br;
    bit          m_halt;
    bit          m_iv;
    logic [4:0]  m_rd;
    logic [1:0]  m_wb;
    logic [1:0]  m_jmp;
    logic [1:0]  m_mem;
    bit          m_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        logic [31:0] visible;
        bit          conflict;
        visible = m_busy;
        if (BYP && wb_valid) visible[wb_rd] = 1'b0;
        conflict = ((dec_active_reg & visible) != 32'd0) ||
                   (dec_wb_op != 2'd0 && dec_rd != 5'd0 && visible[dec_rd]);
        if (!dec_valid || m_br || m_halt) return 1'b0;
        if (dec_fault) return 1'b1;
        return !conflict && (!m_iv || iss_ready) && (dec_mem_op == 2'd0 || m_cnt < MEM_MAX);
    endfunction

    task automatic model_clear();
        m_busy = '0; m_cnt = 0; m_br = 0; m_halt = 0; m_iv = 0;
        m_rd = '0; m_wb = '0; m_jmp = '0; m_mem = '0;
    endtask

    task automatic model_step();
        bit acc;
        bit retire_mem;
        acc = m_rdy && !dec_fault;
        if (wb_valid) m_busy[wb_rd] = 1'b0;
        if (acc && dec_wb_op != 2'd0 && dec_rd != 5'd0) m_busy[dec_rd] = 1'b1;
        retire_mem = mem_done && m_cnt > 0;
        if (acc && dec_mem_op != 2'd0) m_cnt = m_cnt + 1;
        if (retire_mem) m_cnt = m_cnt - 1;
        if (m_br && br_resolve) m_br = 0;
        if (acc && dec_jmp_op != 2'd0) m_br = 1;
        if (m_rdy && dec_fault) m_halt = 1;
        if (acc) begin
            m_iv = 1; m_rd = dec_rd; m_wb = dec_wb_op; m_jmp = dec_jmp_op; m_mem = dec_mem_op;
        end else if (iss_ready) begin
            m_iv = 0;
        end
    endtask

    task automatic compare_all();
        check("dec_ready",  32'(dec_ready),  32'(m_rdy));
        check("iss_valid",  32'(iss_valid),  32'(m_iv));
        check("iss_rd",     32'(iss_rd),     32'(m_rd));
        check("iss_wb_op",  32'(iss_wb_op),  32'(m_wb));
        check("iss_jmp_op", 32'(iss_jmp_op), 32'(m_jmp));
        check("iss_mem_op", 32'(iss_mem_op), 32'(m_mem));
        check("busy_regs",  busy_regs,       m_busy);
        check("fault_o",    32'(fault_o),    32'(m_halt));
        check("halted",     32'(halted),     32'(m_halt));
    endtask

    // Called just after a rising edge with inputs already driven; exp_rdy < 0 means no literal pin.
    task automatic cycle(input int exp_rdy);
        #4;
        m_rdy = model_ready();
        compare_all();
        if (exp_rdy >= 0) check("lit_dec_ready", 32'(dec_ready), 32'(exp_rdy));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #4;
        m_rdy = model_ready();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_rd = '0; dec_active_reg = '0; dec_wb_op = '0; dec_jmp_op = '0;
        dec_mem_op = '0; dec_fault = 0; iss_ready = 1; wb_valid = 0; wb_rd = '0;
        mem_done = 0; br_resolve = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mask;
        idle_inputs();
        do_reset();
        check("rst_busy", busy_regs, 32'd0);
        check("rst_iss_valid", 32'(iss_valid), 32'd0);

        // RAW stall on x5, released by its writeback
        dec_valid = 1; dec_rd = 5'd5; dec_wb_op = 2'd1;
        cycle(1);
        dec_rd = 5'd6; dec_active_reg = 32'h20;
        cycle(0);
        wb_valid = 1; wb_rd = 5'd5;
        if (BYP) cycle(1);
        else begin
            cycle(0);
            wb_valid = 0;
            cycle(1);
        end
        check("x5_cleared", 32'(busy_regs[5]), 32'd0);
        check("x6_set", 32'(busy_regs[6]), 32'd1);
        dec_valid = 0; dec_active_reg = '0; wb_valid = 1; wb_rd = 5'd6;
        cycle(-1);
        wb_valid = 0;

        // memory-op limit
        dec_valid = 1; dec_rd = 5'd0; dec_wb_op = 2'd0; dec_mem_op = 2'd1;
        cycle(1); cycle(1); cycle(0);
        mem_done = 1;
        cycle(0); cycle(1);
        mem_done = 0;
        cycle(1); cycle(0);
        dec_valid = 0; mem_done = 1;
        cycle(-1); cycle(-1); cycle(-1);
        dec_valid = 1; mem_done = 0;
        cycle(1); cycle(1); cycle(0);
        dec_valid = 0; mem_done = 1;
        cycle(-1); cycle(-1);
        mem_done = 0;

        // jump waits for resolution
        dec_valid = 1; dec_mem_op = 2'd0; dec_jmp_op = 2'd1;
        cycle(1);
        dec_jmp_op = 2'd0;
        repeat (5) cycle(0);
        br_resolve = 1;
        cycle(0);
        br_resolve = 0;
        cycle(1);
        dec_valid = 0;
        cycle(-1);

        // fault with x3 busy
        dec_valid = 1; dec_rd = 5'd3; dec_wb_op = 2'd1;
        cycle(1);
        dec_fault = 1; dec_rd = 5'd4; dec_active_reg = 32'h8;
        cycle(1);
        check("fault_sticky", 32'(fault_o), 32'd1);
        check("halted_set", 32'(halted), 32'd1);
        dec_fault = 0; dec_active_reg = '0;
        cycle(0); cycle(0);
        dec_valid = 0;
        do_reset();
        check("rst2_busy", busy_regs, 32'd0);
        check("rst2_fault", 32'(fault_o), 32'd0);
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_iss_rd", 32'(iss_rd), 32'd0);

        // execute back-pressure
        dec_valid = 1; dec_rd = 5'd9; dec_wb_op = 2'd1; iss_ready = 0;
        cycle(1);
        dec_rd = 5'd10;
        repeat (4) begin
            cycle(0);
            check("iss_rd_hold", 32'(iss_rd), 32'd9);
        end
        iss_ready = 1;
        cycle(1);
        check("iss_valid_b2b", 32'(iss_valid), 32'd1);
        check("iss_rd_new", 32'(iss_rd), 32'd10);
        dec_valid = 0;
        cycle(-1);

        // set beats clear on the same register; x0 never busy
        dec_valid = 1; dec_rd = 5'd7; wb_valid = 1; wb_rd = 5'd7;
        cycle(1);
        check("x7_set_wins", 32'(busy_regs[7]), 32'd1);
        dec_valid = 0; wb_rd = 5'd0;
        cycle(-1);
        check("x0_zero", 32'(busy_regs[0]), 32'd0);
        check("x7_kept", 32'(busy_regs[7]), 32'd1);
        wb_rd = 5'd7;  cycle(-1);
        wb_rd = 5'd9;  cycle(-1);
        wb_rd = 5'd10; cycle(-1);
        check("all_clear", busy_regs, 32'd0);
        idle_inputs();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            mask = '0;
            if ($urandom_range(0, 1) == 1) mask[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 3) == 0) mask[$urandom_range(0, 7)] = 1'b1;
            dec_valid      = ($urandom_range(0, 3) != 0);
            dec_rd         = 5'($urandom_range(0, 7));
            dec_active_reg = mask;
            dec_wb_op      = 2'($urandom_range(0, 2));
            dec_jmp_op     = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            dec_mem_op     = 2'($urandom_range(0, 2));
            dec_fault      = ($urandom_range(0, 149) == 0);
            iss_ready      = ($urandom_range(0, 3) != 0);
            wb_valid       = ($urandom_range(0, 2) == 0);
            wb_rd          = 5'($urandom_range(0, 7));
            mem_done       = ($urandom_range(0, 2) == 0);
            br_resolve     = ($urandom_range(0, 3) == 0);
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0)
                do_reset();
            else
                cycle(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
